// File: rtl/dec_3_8_pkg.sv
// Shared sizing and decode helper for the registered 3-to-8 decoder.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   SEL_W   width of the binary select
//   OUT_W   width of the one-hot output, always 2**SEL_W
//   onehot  combinational reference decode: en ? (1 << a) : '0
package dec_3_8_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 2 ** SEL_W;

  function automatic logic [OUT_W-1:0] onehot(input logic en, input logic [SEL_W-1:0] a);
    logic [OUT_W-1:0] res;
    res = '0;
    if (en) begin
      res[a] = 1'b1;
    end
    return res;
  endfunction

endpackage : dec_3_8_pkg

// File: rtl/dec_3_8_core.sv
// Combinational 3-to-8 one-hot decode with enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   en      decode enable; when low y_next is all zeros
//   a       binary select
//   y_next  one-hot decode of a, or zero when disabled
module dec_3_8_core
  import dec_3_8_pkg::*;
(
  input  logic             en,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] y_next
);

  always_comb begin
    // Zero default keeps the block latch-free and makes an unknown select
    // decode to "no line selected" rather than holding a stale value.
    y_next = '0;
    if (en) begin
      case (a)
        3'd0:    y_next = 8'b0000_0001;
        3'd1:    y_next = 8'b0000_0010;
        3'd2:    y_next = 8'b0000_0100;
        3'd3:    y_next = 8'b0000_1000;
        3'd4:    y_next = 8'b0001_0000;
        3'd5:    y_next = 8'b0010_0000;
        3'd6:    y_next = 8'b0100_0000;
        3'd7:    y_next = 8'b1000_0000;
        default: y_next = '0;
      endcase
    end
  end

endmodule : dec_3_8_core

// File: rtl/dec_3_8.sv
// Registered 3-to-8 one-hot decoder with enable (select-line / write-strobe generator).
// Latency: 1 cycle from en/a to y; synchronous active-high rst clears y on the edge.
// Backpressure: none; a new select is accepted every cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, priority over en and a
//   en     decode enable
//   a      binary select
//   y      registered one-hot decode (all zeros when disabled or in reset)
//   y_vld  only when DEC_3_8_VALID_EN is defined: registered copy of en, aligned with y
//
// Build option: define DEC_3_8_VALID_EN to add the y_vld output.
module dec_3_8
  import dec_3_8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_W-1:0] y
`ifdef DEC_3_8_VALID_EN
  ,
  output logic             y_vld
`endif
);

  logic [OUT_W-1:0] y_next;

  dec_3_8_core u_core (
    .en     (en),
    .a      (a),
    .y_next (y_next)
  );

  // Output register: keeps y glitch-free and aligned to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= y_next;
    end
  end

`ifdef DEC_3_8_VALID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      y_vld <= 1'b0;
    end else begin
      y_vld <= en;
    end
  end

  // At most one select line may ever be active.
  a_onehot0 : assert property (@(posedge clk) $onehot0(y));
  // The cycle after reset the decode must be idle.
  a_rst_clear : assert property (@(posedge clk) rst |=> (y == '0 && !y_vld));
`endif

endmodule : dec_3_8

// File: tb/tb_dec_3_8.sv
module tb_dec_3_8;
  import dec_3_8_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic [SEL_W-1:0] a   = '0;
  logic [OUT_W-1:0] y;
`ifdef DEC_3_8_VALID_EN
  logic             y_vld;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: expected values pushed at drive time, popped when the DUT output is sampled.
  logic [OUT_W-1:0] exp_y_q[$];
  logic             exp_vld_q[$];

  dec_3_8 dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .a   (a),
    .y   (y)
`ifdef DEC_3_8_VALID_EN
    ,
    .y_vld (y_vld)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Independent reference: shift a single 1 up by the select, or zero.
  function automatic logic [OUT_W-1:0] ref_dec(input logic r, input logic e, input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] one;
    one = 8'd1;
    if (r || !e) return '0;
    return one << s;
  endfunction

  // Drive one cycle of stimulus (away from the edge), push the expectation,
  // then sample just after the clock edge and compare against the popped entry.
  task automatic step(input string tag, input logic r, input logic e, input logic [SEL_W-1:0] s);
    logic [OUT_W-1:0] ey;
    logic             ev;
    rst = r;
    en  = e;
    a   = s;
    exp_y_q.push_back(ref_dec(r, e, s));
    exp_vld_q.push_back(!r && e);
    @(posedge clk);
    #1;
    ey = exp_y_q.pop_front();
    ev = exp_vld_q.pop_front();
    chk(tag, y, ey);
    chk({tag, "_onehot0"}, ($countones(y) <= 1) ? 8'd1 : 8'd0, 8'd1);
`ifdef DEC_3_8_VALID_EN
    chk({tag, "_vld"}, {7'd0, y_vld}, {7'd0, ev});
`else
    if (ev === 1'bx) chk({tag, "_vld_x"}, 8'd0, 8'd1);
`endif
  endtask

  initial begin
    logic [SEL_W-1:0] s;
    logic             e;
    logic [OUT_W-1:0] hw;

    // Package helper against the independent model.
    for (int i = 0; i < OUT_W; i++) begin
      s = SEL_W'(i);
      chk("pkg_onehot_en1", onehot(1'b1, s), ref_dec(1'b0, 1'b1, s));
      chk("pkg_onehot_en0", onehot(1'b0, s), 8'd0);
    end

    // 1. Reset held for two edges with enable high and a=101.
    step("reset0", 1'b1, 1'b1, 3'b101);
    step("reset1", 1'b1, 1'b1, 3'b101);

    // 2. Disabled.
    step("disable", 1'b0, 1'b0, 3'b000);

    // 3. Directed decode, with literal expectations.
    step("dir_001", 1'b0, 1'b1, 3'b001);
    chk("dir_001_lit", y, 8'b0000_0010);
    step("dir_010", 1'b0, 1'b1, 3'b010);
    chk("dir_010_lit", y, 8'b0000_0100);
    step("dir_011", 1'b0, 1'b1, 3'b011);
    chk("dir_011_lit", y, 8'b0000_1000);
    step("dir_100", 1'b0, 1'b1, 3'b100);
    chk("dir_100_lit", y, 8'b0001_0000);

    // 4. Exhaustive sweep, enabled then disabled.
    for (int i = 0; i < OUT_W; i++) begin
      step("sweep_en1", 1'b0, 1'b1, SEL_W'(i));
    end
    chk("sweep_top_lit", y, 8'b1000_0000);
    for (int i = 0; i < OUT_W; i++) begin
      step("sweep_en0", 1'b0, 1'b0, SEL_W'(i));
    end

    // 5. Random vectors.
    for (int i = 0; i < 40; i++) begin
      e = 1'($urandom_range(0, 1));
      s = SEL_W'($urandom_range(0, OUT_W - 1));
      step("random", 1'b0, e, s);
    end

    // 6. Reset pulse mid-stream, then resume with the same inputs.
    step("mid_pre", 1'b0, 1'b1, 3'b011);
    step("mid_rst", 1'b1, 1'b1, 3'b110);
    chk("mid_rst_lit", y, 8'b0000_0000);
    step("mid_resume", 1'b0, 1'b1, 3'b110);
    hw = y;
    chk("mid_resume_lit", hw, 8'b0100_0000);

    if (exp_y_q.size() != 0) chk("queue_drain", 8'(exp_y_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_dec_3_8
